conv_window_accumulator: RTL and testbench

Parametrised multiply-accumulate post-stage that sums a fixed window of product samples (default 9, one 3x3 convolution output) into one result. It sits between the product multiplier and the output/feature-map writer. It adds a valid/ready handshake on both sides, a configurable accumulator width, a signed mode, saturate or wrap overflow handling, and a synchronous abandon (clear) of the current window.

---
 rtl/conv_window_accumulator.sv | 150 +++++++++++++++
 tb/tb_conv_window_accumulator.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_accumulator.sv
// conv_window_accumulator: sums a fixed window of product samples into one result,
// with valid/ready on both sides, signed/unsigned extension, saturate or wrap on
// overflow, a sticky overflow flag per window and a synchronous window abandon.
module conv_window_accumulator #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned ACC_W       = 16,
   parameter int unsigned WINDOW      = 9,
   parameter int unsigned SIGNED_MODE = 0,
   parameter int unsigned SATURATE    = 1,
   parameter int unsigned CNT_W       = $clog2(WINDOW + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] acc_in,
   input  logic              clear,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              sat_flag,
   output logic [CNT_W-1:0]  fill_cnt
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

   logic [ACC_W-1:0]         r_acc;
   logic                     r_sticky;
   logic [CNT_W-1:0]         r_fill;
   logic                     r_out_valid;
   logic [ACC_W-1:0]         r_acc_out;
   logic                     r_sat;

   logic signed [DATA_W-1:0] w_in_s;
   logic [ACC_W-1:0]         w_ext;
   logic [ACC_W:0]           w_sum;
   logic                     w_ovf;
   logic [ACC_W-1:0]         w_clamp;
   logic [ACC_W-1:0]         w_add;
   logic                     w_last;
   logic                     w_accept;
   logic                     w_first;
   logic [ACC_W-1:0]         w_step_acc;
   logic                     w_step_sticky;
   logic                     w_complete;

   logic [ACC_W-1:0]         w_acc_nxt;
   logic                     w_sticky_nxt;
   logic [CNT_W-1:0]         w_fill_nxt;
   logic                     w_ov_nxt;
   logic [ACC_W-1:0]         w_out_nxt;
   logic                     w_sat_nxt;

   assign w_in_s = $signed(acc_in);

   // Widen the incoming sample to accumulator width (sign- or zero-extend).
   always_comb begin
      if (SIGNED_MODE != 0) begin
         w_ext = ACC_W'(w_in_s);
      end else begin
         w_ext = ACC_W'(acc_in);
      end
   end

   // One extra bit so the unsigned carry out is directly visible.
   assign w_sum = {1'b0, r_acc} + {1'b0, w_ext};

   // Overflow detection and clamp value for the running addition.
   always_comb begin
      w_ovf   = w_sum[ACC_W];
      w_clamp = '1;
      if (SIGNED_MODE != 0) begin
         w_ovf   = (r_acc[ACC_W-1] == w_ext[ACC_W-1]) && (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
         // Both operands share a sign on overflow, so r_acc's sign picks max or min.
         w_clamp = {r_acc[ACC_W-1], {(ACC_W-1){~r_acc[ACC_W-1]}}};
      end
      w_add = (w_ovf && (SATURATE != 0)) ? w_clamp : w_sum[ACC_W-1:0];
   end

   assign w_last   = (r_fill == LAST_IDX);
   // Only the completing sample is held off while a result is stalled.
   assign in_ready = !(r_out_valid && !out_ready && w_last);
   assign w_accept = in_valid && in_ready;

   // A clear makes the accepted sample the first element of a fresh window.
   assign w_first       = clear || (r_fill == '0);
   assign w_step_acc    = w_first ? w_ext : w_add;
   assign w_step_sticky = w_first ? 1'b0 : (r_sticky | w_ovf);
   assign w_complete    = w_accept && (clear ? (WINDOW == 1) : w_last);

   // Next-state: window accumulation, completion hand-off and output drain.
   always_comb begin
      w_acc_nxt    = r_acc;
      w_sticky_nxt = r_sticky;
      w_fill_nxt   = r_fill;
      w_ov_nxt     = r_out_valid;
      w_out_nxt    = r_acc_out;
      w_sat_nxt    = r_sat;

      if (r_out_valid && out_ready) begin
         w_ov_nxt = 1'b0;
      end

      if (clear) begin
         w_acc_nxt    = '0;
         w_sticky_nxt = 1'b0;
         w_fill_nxt   = '0;
      end

      if (w_accept) begin
         if (w_complete) begin
            w_out_nxt    = w_step_acc;
            w_sat_nxt    = w_step_sticky;
            w_ov_nxt     = 1'b1;
            w_acc_nxt    = '0;
            w_sticky_nxt = 1'b0;
            w_fill_nxt   = '0;
         end else begin
            w_acc_nxt    = w_step_acc;
            w_sticky_nxt = w_step_sticky;
            w_fill_nxt   = clear ? CNT_W'(1) : r_fill + CNT_W'(1);
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_acc       <= '0;
         r_sticky    <= 1'b0;
         r_fill      <= '0;
         r_out_valid <= 1'b0;
         r_acc_out   <= '0;
         r_sat       <= 1'b0;
      end else begin
         r_acc       <= w_acc_nxt;
         r_sticky    <= w_sticky_nxt;
         r_fill      <= w_fill_nxt;
         r_out_valid <= w_ov_nxt;
         r_acc_out   <= w_out_nxt;
         r_sat       <= w_sat_nxt;
      end
   end

   assign out_valid = r_out_valid;
   assign acc_out   = r_acc_out;
   assign sat_flag  = r_sat;
   assign fill_cnt  = r_fill;

endmodule

// File: tb/tb_conv_window_accumulator.sv
// tb_conv_window_accumulator: four accumulator configurations share one stimulus
// stream; an integer-arithmetic model predicts results into a scoreboard queue
// that a separate monitor drains whenever a new result is presented.
module tb_conv_window_accumulator;

   localparam int NI  = 4;
   localparam int WIN = 9;
   localparam int CW  = $clog2(WIN + 1);

   // Per-instance configuration: width, signedness, saturate(1)/wrap(0).
   localparam int ACC_WS [NI] = '{16, 8, 8, 10};
   localparam int SGNS   [NI] = '{0, 0, 0, 1};
   localparam int SATS   [NI] = '{1, 1, 0, 1};

   logic          clk       = 1'b0;
   logic          rst       = 1'b0;
   logic          in_valid  = 1'b0;
   logic [7:0]    acc_in    = '0;
   logic          clear     = 1'b0;
   logic          out_ready = 1'b0;

   logic          rdy_a [NI];
   logic          ov_a  [NI];
   logic          sat_a [NI];
   logic [15:0]   out_a [NI];
   logic [CW-1:0] fc_a  [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int AW = ACC_WS[g];
      logic [AW-1:0] w_out;
      conv_window_accumulator #(
         .DATA_W      (8),
         .ACC_W       (AW),
         .WINDOW      (WIN),
         .SIGNED_MODE (SGNS[g]),
         .SATURATE    (SATS[g])
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (rdy_a[g]),
         .acc_in    (acc_in),
         .clear     (clear),
         .out_valid (ov_a[g]),
         .out_ready (out_ready),
         .acc_out   (w_out),
         .sat_flag  (sat_a[g]),
         .fill_cnt  (fc_a[g])
      );
      assign out_a[g] = 16'(w_out);
   end

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int inst, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s[%0d] @%0t: got %0d, expected %0d", name, inst, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [NI-1:0][15:0] val;
      logic [NI-1:0]       sat;
   } res_t;

   res_t   sb_q[$];
   bit     m_ov   = 1'b0;
   int     m_fill = 0;
   longint m_acc    [NI];
   bit     m_sticky [NI];
   longint m_hval   [NI];
   bit     m_hsat   [NI];

   function automatic longint vmax(input int i);
      if (SGNS[i] != 0) return (longint'(1) << (ACC_WS[i] - 1)) - 1;
      return (longint'(1) << ACC_WS[i]) - 1;
   endfunction

   function automatic longint vmin(input int i);
      if (SGNS[i] != 0) return -(longint'(1) << (ACC_WS[i] - 1));
      return 0;
   endfunction

   function automatic longint extv(input int i, input logic [7:0] s);
      if (SGNS[i] != 0 && s[7]) return longint'(s) - 256;
      return longint'(s);
   endfunction

   // Two's-complement bit pattern of a model value at the instance width.
   function automatic logic [15:0] pat(input int i, input longint v);
      longint m;
      m = (longint'(1) << ACC_WS[i]) - 1;
      return 16'(v & m);
   endfunction

   function automatic bit model_rdy();
      return !(m_ov && !out_ready && m_fill == WIN - 1);
   endfunction

   // Add one sample to instance i's running total with overflow handling.
   task automatic model_add(input int i, input longint e);
      longint sum;
      longint span;
      sum = m_acc[i] + e;
      if (sum > vmax(i) || sum < vmin(i)) begin
         m_sticky[i] = 1'b1;
         if (SATS[i] != 0) begin
            sum = (sum > vmax(i)) ? vmax(i) : vmin(i);
         end else begin
            span = longint'(1) << ACC_WS[i];
            sum  = sum & (span - 1);
            if (sum > vmax(i)) sum = sum - span;
         end
      end
      m_acc[i] = sum;
   endtask

   // Advance the model across one rising edge using the currently driven inputs.
   task automatic model_step();
      bit   accept;
      bit   complete;
      res_t r;
      if (!rst) begin
         m_ov   = 1'b0;
         m_fill = 0;
         for (int i = 0; i < NI; i++) begin
            m_acc[i]    = 0;
            m_sticky[i] = 1'b0;
            m_hval[i]   = 0;
            m_hsat[i]   = 1'b0;
         end
         return;
      end
      accept   = in_valid && model_rdy();
      complete = 1'b0;
      if (clear) begin
         m_fill = 0;
         for (int i = 0; i < NI; i++) begin
            m_acc[i]    = 0;
            m_sticky[i] = 1'b0;
         end
      end
      if (accept) begin
         for (int i = 0; i < NI; i++) begin
            if (m_fill == 0) begin
               m_acc[i]    = extv(i, acc_in);
               m_sticky[i] = 1'b0;
            end else begin
               model_add(i, extv(i, acc_in));
            end
         end
         if (m_fill == WIN - 1) complete = 1'b1;
         else m_fill++;
      end
      if (complete) begin
         for (int i = 0; i < NI; i++) begin
            r.val[i]    = pat(i, m_acc[i]);
            r.sat[i]    = m_sticky[i];
            m_hval[i]   = m_acc[i];
            m_hsat[i]   = m_sticky[i];
            m_acc[i]    = 0;
            m_sticky[i] = 1'b0;
         end
         sb_q.push_back(r);
         m_ov   = 1'b1;
         m_fill = 0;
      end else if (m_ov && out_ready) begin
         m_ov = 1'b0;
      end
   endtask

   // Drive one cycle of inputs, compare control/held outputs, then advance the model.
   task automatic cycle(input logic r, input logic iv, input logic [7:0] d, input logic cl,
                        input logic ordy);
      @(negedge clk);
      rst       = r;
      in_valid  = iv;
      acc_in    = d;
      clear     = cl;
      out_ready = ordy;
      #1;
      for (int i = 0; i < NI; i++) begin
         check("in_ready", i, longint'(rdy_a[i]), longint'(model_rdy()));
         check("out_valid", i, longint'(ov_a[i]), longint'(m_ov));
         check("fill_cnt", i, longint'(fc_a[i]), longint'(m_fill));
         check("held_acc_out", i, longint'(out_a[i]), longint'(pat(i, m_hval[i])));
         check("held_sat_flag", i, longint'(sat_a[i]), longint'(m_hsat[i]));
      end
      model_step();
   endtask

   // ---------------- monitor ----------------
   bit prev_ov = 1'b0;

   initial begin
      res_t r;
      forever begin
         @(posedge clk);
         #1;
         // A new result appears when out_valid is high and the slot was empty or drained.
         if (ov_a[0] && (!prev_ov || out_ready)) begin
            if (sb_q.size() == 0) begin
               check("unexpected_result", 0, 1, 0);
            end else begin
               r = sb_q.pop_front();
               for (int i = 0; i < NI; i++) begin
                  check("acc_out", i, longint'(out_a[i]), longint'(r.val[i]));
                  check("sat_flag", i, longint'(sat_a[i]), longint'(r.sat[i]));
               end
            end
         end
         prev_ov = ov_a[0];
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < NI; i++) begin
         m_acc[i]    = 0;
         m_sticky[i] = 1'b0;
         m_hval[i]   = 0;
         m_hsat[i]   = 1'b0;
      end

      repeat (2) cycle(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);

      // Two back-to-back windows of 10s.
      repeat (18) cycle(1'b1, 1'b1, 8'd10, 1'b0, 1'b1);
      repeat (2) cycle(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);

      // Overflow patterns, then mixed +5/-3.
      repeat (9) cycle(1'b1, 1'b1, 8'd200, 1'b0, 1'b1);
      repeat (9) cycle(1'b1, 1'b1, 8'h80, 1'b0, 1'b1);
      repeat (9) cycle(1'b1, 1'b1, 8'h7F, 1'b0, 1'b1);
      for (int k = 0; k < 9; k++) cycle(1'b1, 1'b1, (k % 2 == 0) ? 8'd5 : 8'hFD, 1'b0, 1'b1);
      repeat (2) cycle(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);

      // Backpressure: stall after the first result, drain and accept in one cycle.
      repeat (9) cycle(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b1);
      repeat (12) cycle(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b1);
      repeat (3) cycle(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
      repeat (2) cycle(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);

      // Clear with no sample, then clear together with an accepted sample.
      repeat (4) cycle(1'b1, 1'b1, 8'd7, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 8'd0, 1'b1, 1'b1);
      repeat (9) cycle(1'b1, 1'b1, 8'd1, 1'b0, 1'b1);
      repeat (3) cycle(1'b1, 1'b1, 8'd2, 1'b0, 1'b1);
      cycle(1'b1, 1'b1, 8'd3, 1'b1, 1'b1);
      repeat (8) cycle(1'b1, 1'b1, 8'd4, 1'b0, 1'b1);

      // Held result survives clears while stalled.
      repeat (9) cycle(1'b1, 1'b1, 8'd9, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 8'd1, 1'b1, 1'b0);
      repeat (2) cycle(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);

      // Reset mid-window while a result is held.
      repeat (12) cycle(1'b1, 1'b1, 8'd5, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 8'd5, 1'b0, 1'b0);
      repeat (2) cycle(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);

      // Randomized traffic with occasional clear and reset.
      repeat (600) begin
         cycle(($urandom % 64) != 0, ($urandom % 4) != 0, 8'($urandom), ($urandom % 20) == 0,
               ($urandom % 4) != 0);
      end

      repeat (3) cycle(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
      @(posedge clk);
      #2;
      check("scoreboard_empty", 0, longint'(sb_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
